// File: rtl/execute_stage_mc_pkg.sv
// exec_pkg: op encodings, FSM state encoding and branch helpers shared by the execute stage.
package exec_pkg;

    localparam int EXEC_OP_W = 5;

    localparam logic [EXEC_OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [EXEC_OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [EXEC_OP_W-1:0] OP_AND  = 5'd2;
    localparam logic [EXEC_OP_W-1:0] OP_OR   = 5'd3;
    localparam logic [EXEC_OP_W-1:0] OP_XOR  = 5'd4;
    localparam logic [EXEC_OP_W-1:0] OP_SLT  = 5'd5;
    localparam logic [EXEC_OP_W-1:0] OP_SLTU = 5'd6;
    localparam logic [EXEC_OP_W-1:0] OP_SLL  = 5'd7;
    localparam logic [EXEC_OP_W-1:0] OP_SRL  = 5'd8;
    localparam logic [EXEC_OP_W-1:0] OP_SRA  = 5'd9;
    localparam logic [EXEC_OP_W-1:0] OP_MUL  = 5'd10;
    localparam logic [EXEC_OP_W-1:0] OP_BEQ  = 5'd11;
    localparam logic [EXEC_OP_W-1:0] OP_BNE  = 5'd12;
    localparam logic [EXEC_OP_W-1:0] OP_BLT  = 5'd13;
    localparam logic [EXEC_OP_W-1:0] OP_BGE  = 5'd14;
    localparam logic [EXEC_OP_W-1:0] OP_JMP  = 5'd15;
    localparam logic [EXEC_OP_W-1:0] OP_LDST = 5'd16;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MUL_BUSY = 1'b1;

    function automatic logic is_branch(input logic [EXEC_OP_W-1:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JMP};
    endfunction

    // eq/lt come from the datapath so this stays independent of XLEN
    function automatic logic br_taken(input logic [EXEC_OP_W-1:0] op, input logic eq, input logic lt);
        return (op == OP_BEQ && eq) || (op == OP_BNE && !eq) ||
               (op == OP_BLT && lt) || (op == OP_BGE && !lt) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/execute_stage_mc_mul_iter.sv
// exec_mul_iter: iterative shift-add multiplier retiring MUL_BPC multiplier bits per cycle.
// done_o and product_o are valid combinationally in the final iteration cycle.
module exec_mul_iter #(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int N  = XLEN / MUL_BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [XLEN-1:0] partial;

    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_BPC; j++)
            partial = partial + (mplier_q[j] ? (mcand_q << j) : '0);
    end

    assign done_o    = busy_q && (cnt_q == CW'(N - 1));
    assign product_o = acc_q + partial;

    always_comb begin
        busy_d   = abort_i ? 1'b0 : start_i ? 1'b1 : done_o ? 1'b0 : busy_q;
        cnt_d    = start_i ? '0 : busy_q ? cnt_q + 1'b1 : cnt_q;
        mcand_d  = start_i ? op1_i : busy_q ? mcand_q << MUL_BPC : mcand_q;
        mplier_d = start_i ? op2_i : busy_q ? mplier_q >> MUL_BPC : mplier_q;
        acc_d    = start_i ? '0 : busy_q ? product_o : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/execute_stage_mc.sv
// execute_stage_mc: registered execute stage with valid/ready on both sides, single-cycle ALU,
// branch resolve, effective address and an iterative multiplier sharing one output register.
module execute_stage_mc
    import exec_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 1,
    parameter int OP_W    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [OP_W-1:0] in_op_i,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [XLEN-1:0] in_op1_i,
    input  logic [XLEN-1:0] in_op2_i,
    input  logic [XLEN-1:0] in_offset_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_result_o,
    output logic [XLEN-1:0] out_addr_o,
    output logic            out_branch_o
);

    localparam int SW = $clog2(XLEN);

    logic [EXEC_OP_W-1:0] op;
    logic [SW-1:0]        sh;
    logic                 eq, lt, ltu, br;
    logic [XLEN-1:0]      alu_res, ea;

    logic [0:0]      state_q, state_d;
    logic            valid_q, valid_d, branch_q, branch_d;
    logic [XLEN-1:0] result_q, result_d, addr_q, addr_d, mul_addr_q, mul_addr_d;
    logic            accept, is_mul, load_alu, load_mul, mul_done;
    logic [XLEN-1:0] mul_prod;

    assign op  = EXEC_OP_W'(in_op_i);
    assign sh  = in_op2_i[SW-1:0];
    assign eq  = in_op1_i == in_op2_i;
    assign lt  = $signed(in_op1_i) < $signed(in_op2_i);
    assign ltu = in_op1_i < in_op2_i;
    assign br  = br_taken(op, eq, lt);
    assign ea  = (is_branch(op) ? in_pc_i : in_op1_i) + in_offset_i;

    // branch and undefined ops fall to the zero default
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = in_op1_i + in_op2_i;
            OP_SUB:  alu_res = in_op1_i - in_op2_i;
            OP_AND:  alu_res = in_op1_i & in_op2_i;
            OP_OR:   alu_res = in_op1_i | in_op2_i;
            OP_XOR:  alu_res = in_op1_i ^ in_op2_i;
            OP_SLT:  alu_res = XLEN'(lt);
            OP_SLTU: alu_res = XLEN'(ltu);
            OP_SLL:  alu_res = in_op1_i << sh;
            OP_SRL:  alu_res = in_op1_i >> sh;
            OP_SRA:  alu_res = $unsigned($signed(in_op1_i) >>> sh);
            OP_LDST: alu_res = in_op2_i;
            default: alu_res = '0;
        endcase
    end

    assign in_ready_o = (state_q == ST_IDLE) && (!valid_q || out_ready_i) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign is_mul     = op == OP_MUL;
    assign load_alu   = accept && !is_mul;
    assign load_mul   = (state_q == ST_MUL_BUSY) && mul_done && !flush_i;

    exec_mul_iter #(.XLEN(XLEN), .MUL_BPC(MUL_BPC)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept && is_mul),
        .abort_i  (flush_i),
        .op1_i    (in_op1_i),
        .op2_i    (in_op2_i),
        .done_o   (mul_done),
        .product_o(mul_prod)
    );

    always_comb begin
        state_d    = flush_i ? ST_IDLE : (accept && is_mul) ? ST_MUL_BUSY : load_mul ? ST_IDLE : state_q;
        valid_d    = flush_i ? 1'b0 : (load_alu || load_mul) ? 1'b1 : out_ready_i ? 1'b0 : valid_q;
        result_d   = load_alu ? alu_res : load_mul ? mul_prod : result_q;
        addr_d     = load_alu ? ea : load_mul ? mul_addr_q : addr_q;
        branch_d   = load_alu ? br : load_mul ? 1'b0 : branch_q;
        mul_addr_d = (accept && is_mul) ? ea : mul_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            result_q   <= '0;
            addr_q     <= '0;
            branch_q   <= 1'b0;
            mul_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            addr_q     <= addr_d;
            branch_q   <= branch_d;
            mul_addr_q <= mul_addr_d;
        end
    end

    assign out_valid_o  = valid_q;
    assign out_result_o = result_q;
    assign out_addr_o   = addr_q;
    assign out_branch_o = branch_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
// tb_execute_stage_mc: table-driven vectors plus hand sequences for MUL latency, back-pressure, flush and reset.
module tb_execute_stage_mc;
    import exec_pkg::*;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] pc, op1, op2, off, res, addr;
        logic        br, chk;
    } vec_t;

    typedef struct {
        logic [31:0] res, addr;
        logic        br, chk;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, out_branch;
    logic [4:0]  in_op = '0;
    logic [31:0] in_pc = '0, in_op1 = '0, in_op2 = '0, in_off = '0;
    logic [31:0] out_result, out_addr;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0, bad = 0, beats = 0, cyc = 0;

    execute_stage_mc #(.XLEN(32), .MUL_BPC(1), .OP_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_op_i     (in_op),
        .in_pc_i     (in_pc),
        .in_op1_i    (in_op1),
        .in_op2_i    (in_op2),
        .in_offset_i (in_off),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_result_o(out_result),
        .out_addr_o  (out_addr),
        .out_branch_o(out_branch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every transferred beat pops the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            beats++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: got res=%h addr=%h br=%b, required no beat", out_result, out_addr, out_branch);
            end else begin
                mon_e = sb.pop_front();
                if (out_addr !== mon_e.addr || out_branch !== mon_e.br || (mon_e.chk && out_result !== mon_e.res)) begin
                    bad++;
                    $display("FAIL beat: got res=%h addr=%h br=%b, required res=%h addr=%h br=%b",
                             out_result, out_addr, out_branch, mon_e.res, mon_e.addr, mon_e.br);
                end
            end
        end
    end

    function automatic exp_t ex(input logic [31:0] r, input logic [31:0] a, input logic b, input logic c);
        exp_t e;
        e.res = r; e.addr = a; e.br = b; e.chk = c;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    // called just after a posedge; returns just after the accepting posedge with in_valid still high
    task automatic send(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] off, input exp_t e, input bit expect_out);
        int n = 0;
        in_valid = 1'b1; in_op = op; in_pc = pc; in_op1 = a; in_op2 = b; in_off = off;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                if (expect_out) sb.push_back(e);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            if (++n > 200) begin
                total++; bad++;
                $display("FAIL accept_timeout: in_ready stayed 0, required 1");
                break;
            end
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic mul_run(input logic [31:0] a, input logic [31:0] b);
        int busy_bad = 0;
        send(OP_MUL, 32'h0, a, b, 32'h4, ex(a * b, a + 32'h4, 1'b0, 1'b1), 1'b1);
        in_valid = 1'b0;
        repeat (32) begin
            @(negedge clk);
            if (in_ready || out_valid) busy_bad++;
        end
        check("mul_busy", busy_bad, 0);
        @(negedge clk);
        check("mul_lat", out_valid, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[22];
        logic [31:0] a, b, snap_r, snap_a;
        int          stable_bad, quiet, c0, b0;

        tbl[0]  = '{OP_SUB,  32'h0,    32'h5,         32'h7,         32'h0,         32'hFFFF_FFFE, 32'h5,         1'b0, 1'b1};
        tbl[1]  = '{OP_AND,  32'h0,    32'hF0F0,      32'hFF00,      32'h0,         32'hF000,      32'hF0F0,      1'b0, 1'b1};
        tbl[2]  = '{OP_OR,   32'h0,    32'hF0F0,      32'hFF00,      32'h0,         32'hFFF0,      32'hF0F0,      1'b0, 1'b1};
        tbl[3]  = '{OP_XOR,  32'h0,    32'hF0F0,      32'hFF00,      32'h0,         32'h0FF0,      32'hF0F0,      1'b0, 1'b1};
        tbl[4]  = '{OP_SLT,  32'h0,    32'hFFFF_FFFF, 32'h0,         32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[5]  = '{OP_SLTU, 32'h0,    32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[6]  = '{OP_SLL,  32'h0,    32'h1,         32'h3F,        32'h0,         32'h8000_0000, 32'h1,         1'b0, 1'b1};
        tbl[7]  = '{OP_SRL,  32'h0,    32'h8000_0000, 32'h4,         32'h0,         32'h0800_0000, 32'h8000_0000, 1'b0, 1'b1};
        tbl[8]  = '{OP_SRA,  32'h0,    32'h8000_0000, 32'h24,        32'h0,         32'hF800_0000, 32'h8000_0000, 1'b0, 1'b1};
        tbl[9]  = '{OP_BLT,  32'h100,  32'hFFFF_FFFF, 32'h0,         32'h20,        32'h0,         32'h120,       1'b1, 1'b1};
        tbl[10] = '{OP_BEQ,  32'h100,  32'h1,         32'h2,         32'h20,        32'h0,         32'h120,       1'b0, 1'b1};
        tbl[11] = '{OP_BEQ,  32'h100,  32'h5,         32'h5,         32'h20,        32'h0,         32'h120,       1'b1, 1'b1};
        tbl[12] = '{OP_BNE,  32'h200,  32'h1,         32'h2,         32'hFFFF_FFF0, 32'h0,         32'h1F0,       1'b1, 1'b1};
        tbl[13] = '{OP_BGE,  32'h10,   32'hFFFF_FFFF, 32'h0,         32'h4,         32'h0,         32'h14,        1'b0, 1'b1};
        tbl[14] = '{OP_BGE,  32'h10,   32'h0,         32'h0,         32'h4,         32'h0,         32'h14,        1'b1, 1'b1};
        tbl[15] = '{OP_JMP,  32'h1000, 32'h0,         32'h0,         32'h10,        32'h0,         32'h1010,      1'b1, 1'b1};
        tbl[16] = '{OP_LDST, 32'h500,  32'h1000,      32'hABCD,      32'h24,        32'h0,         32'h1024,      1'b0, 1'b0};
        tbl[17] = '{5'd31,   32'h500,  32'h5,         32'h9,         32'h3,         32'h0,         32'h8,         1'b0, 1'b1};
        tbl[18] = '{OP_ADD,  32'h0,    32'hFFFF_FFFF, 32'h2,         32'h2,         32'h1,         32'h1,         1'b0, 1'b1};
        tbl[19] = '{OP_BLT,  32'h0,    32'h0,         32'hFFFF_FFFF, 32'h8,         32'h0,         32'h8,         1'b0, 1'b1};
        tbl[20] = '{OP_SLTU, 32'h0,    32'h0,         32'hFFFF_FFFF, 32'h0,         32'h1,         32'h0,         1'b0, 1'b1};
        tbl[21] = '{OP_SRA,  32'h0,    32'h7FFF_FFFF, 32'h1,         32'h0,         32'h3FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1};

        #12;
        check("rst_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_addr", out_addr, 0);
        check("rst_branch", out_branch, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", in_ready, 1);

        send(OP_ADD, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, ex(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1), 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("add_lat", out_valid, 1);
        check("add_result", out_result, 0);
        check("add_branch", out_branch, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++)
            send(tbl[i].op, tbl[i].pc, tbl[i].op1, tbl[i].op2, tbl[i].off,
                 ex(tbl[i].res, tbl[i].addr, tbl[i].br, tbl[i].chk), 1'b1);
        in_valid = 1'b0;
        drain("table_drain");

        mul_run(32'd7, 32'd6);
        mul_run(32'h8000_0000, 32'h2);
        mul_run(32'h1234_5678, 32'h9ABC_DEF1);
        drain("mul_drain");

        out_ready = 1'b0;
        send(OP_ADD, 32'h0, 32'h7, 32'h8, 32'h0, ex(32'd15, 32'h7, 1'b0, 1'b1), 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        snap_r = out_result;
        snap_a = out_addr;
        check("hold_value", snap_r, 32'd15);
        stable_bad = 0;
        repeat (5) begin
            if (!out_valid || in_ready || out_result !== snap_r || out_addr !== snap_a) stable_bad++;
            @(negedge clk);
        end
        check("hold_stable", stable_bad, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        c0 = cyc;
        b0 = beats;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            send(OP_ADD, 32'h0, a, b, 32'h0, ex(a + b, a, 1'b0, 1'b1), 1'b1);
        end
        check("stream_cycles", cyc - c0, 8);
        in_valid = 1'b0;
        drain("stream_drain");
        check("stream_beats", beats - b0, 9);

        send(OP_MUL, 32'h0, 32'h3, 32'h5, 32'h0, ex(32'h0, 32'h0, 1'b0, 1'b0), 1'b0);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready_low", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_ready_after", in_ready, 1);
        check("flush_valid", out_valid, 0);
        quiet = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        check("flush_quiet", quiet, 0);
        @(posedge clk); #1;
        send(OP_ADD, 32'h0, 32'h10, 32'h20, 32'h0, ex(32'h30, 32'h10, 1'b0, 1'b1), 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_valid", out_valid, 1);
        @(posedge clk); #1;
        drain("flush_drain");

        send(OP_MUL, 32'h0, 32'h9, 32'h9, 32'h0, ex(32'h0, 32'h0, 1'b0, 1'b0), 1'b0);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_result", out_result, 0);
        check("arst_addr", out_addr, 0);
        check("arst_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        check("arst_quiet", quiet, 0);
        @(posedge clk); #1;
        send(OP_SUB, 32'h0, 32'd10, 32'd3, 32'h1, ex(32'd7, 32'd11, 1'b0, 1'b1), 1'b1);
        in_valid = 1'b0;
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
